// File: rtl/ghazi_ram_arb_pkg.sv
// rtl/ghazi_ram_arb_pkg.sv - shared types and constants for the instruction RAM arbiter
package ghazi_ram_arb_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } arb_state_e;

  localparam logic [1:0] RERR_NONE  = 2'b00;
  localparam logic [1:0] RERR_RANGE = 2'b11;
  localparam int unsigned ADDR_W    = 14;

endpackage

// File: rtl/ghazi_ram_wbuf.sv
// rtl/ghazi_ram_wbuf.sv - loader write buffer: small FIFO of {address, data} words
module ghazi_ram_wbuf #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == (PW+1)'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign overflow_o  = overflow_q;
  assign do_pop      = pop_i & ~empty_o;
  // A push against a full buffer still lands when the head leaves in the same cycle.
  assign do_push     = push_i & (~full_o | do_pop);
  assign {head_addr_o, head_data_o} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    if (push_i && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
  end

endmodule

// File: rtl/ghazi_iram_arbiter.sv
// rtl/ghazi_iram_arbiter.sv - boot sequencer and core/loader arbiter for the instruction DFFRAM
module ghazi_iram_arbiter
  import ghazi_ram_arb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DW-1:0]     ld_wdata_i,
  input  logic              ld_done_i,
  input  logic              ld_start_i,
  output logic              ld_full_o,
  output logic              ld_overflow_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DW-1:0]     core_wdata_i,
  input  logic [DW-1:0]     core_wmask_i,
  output logic              core_gnt_o,
  output logic [DW-1:0]     core_rdata_o,
  output logic              core_rvalid_o,
  output logic [1:0]        core_rerror_o,
  output logic              core_rst_no,
  output logic              ram_en_o,
  output logic [DW/8-1:0]   ram_we_o,
  output logic [AW-1:0]     ram_a_o,
  output logic [DW-1:0]     ram_di_o,
  input  logic [DW-1:0]     ram_do_i,
  output logic [1:0]        state_o
);

  localparam int NB = DW / 8;

  arb_state_e    state_q, state_d;
  logic          rr_core_q, rr_core_d;
  logic          core_rst_q, core_rst_d;
  logic          rvalid_q;
  logic [1:0]    rerror_q;
  logic          buf_empty, buf_pop, ld_push;
  logic          core_win, core_gnt, core_oor;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [NB-1:0] core_be;

  // Out-of-range loader words are never buffered, so the FIFO only holds RAM addresses.
  assign ld_push  = ld_we_i & ~(|ld_addr_i[ADDR_W-1:AW]);
  assign core_oor = |core_addr_i[ADDR_W-1:AW];

  ghazi_ram_wbuf #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_wbuf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (ld_push),
    .push_addr_i (ld_addr_i[AW-1:0]),
    .push_data_i (ld_wdata_i),
    .pop_i       (buf_pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .empty_o     (buf_empty),
    .full_o      (ld_full_o),
    .overflow_o  (ld_overflow_o)
  );

  // rr_core_q=1 means the core wins the next contended cycle.
  always_comb begin
    core_win  = 1'b0;
    buf_pop   = 1'b0;
    rr_core_d = rr_core_q;
    if (state_q == RUN) begin
      if (core_req_i && !buf_empty) begin
        core_win  = rr_core_q;
        rr_core_d = ~rr_core_q;
      end else begin
        core_win  = core_req_i;
      end
      buf_pop = ~buf_empty & ~core_win;
    end else begin
      buf_pop = ~buf_empty;
    end
  end

  assign core_gnt = core_req_i & core_win;

  always_comb begin
    core_be = '0;
    for (int i = 0; i < NB; i++) core_be[i] = core_we_i & (|core_wmask_i[8*i +: 8]);
  end

  always_comb begin
    ram_en_o = 1'b0;
    ram_we_o = '0;
    ram_a_o  = core_addr_i[AW-1:0];
    ram_di_o = core_wdata_i;
    if (buf_pop) begin
      ram_en_o = 1'b1;
      ram_we_o = '1;
      ram_a_o  = head_addr;
      ram_di_o = head_data;
    end else if (core_gnt && !core_oor) begin
      ram_en_o = 1'b1;
      ram_we_o = core_be;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (ld_done_i)  state_d = DRAIN;
      DRAIN:   if (buf_empty)  state_d = RUN;
      RUN:     if (ld_start_i) state_d = LOAD;
      default: state_d = LOAD;
    endcase
    // Released one cycle after entering RUN, and pulled low together with the exit from RUN.
    core_rst_d = (state_q == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOAD;
      rr_core_q  <= 1'b0;
      core_rst_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rerror_q   <= RERR_NONE;
    end else begin
      state_q    <= state_d;
      rr_core_q  <= rr_core_d;
      core_rst_q <= core_rst_d;
      rvalid_q   <= core_gnt;
      rerror_q   <= (core_gnt && core_oor) ? RERR_RANGE : RERR_NONE;
    end
  end

  assign core_gnt_o    = core_gnt;
  assign core_rdata_o  = ram_do_i;
  assign core_rvalid_o = rvalid_q;
  assign core_rerror_o = rerror_q;
  assign core_rst_no   = core_rst_q;
  assign state_o       = state_q;

endmodule
